fx3_stream_engine: RTL and testbench
====================================

FX3_STREAM_ENGINE -- requirements
Module: fx3_stream_engine

Interface
REQ-001 The block SHALL expose the following parameters:
- ADC_WIDTH, default 10: sample width in bits, legal range 8..16.
- OUT_WIDTH, default 16: output word width, legal range ADC_WIDTH..32.
- BURST_LEN, default 8192: words per FX3 burst, legal range 2..65535.
- GAP_CYCLES, default 4: minimum idle cycles between bursts, legal range 1..255.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 The block SHALL have the following ports:
- clock  in  1  FX3 GPIF clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- inData  in  ADC_WIDTH  unsigned offset-binary sample from FIFO read side.
- inValid  in  1  inData valid (FIFO not empty).
- inReady  out  1  sample consumed this cycle when inValid&inReady.
- fifoFull  in  1  FIFO full flag (sample loss upstream).
- testMode  in  1  1 = substitute internal ramp for inData.
- th0Ready  in  1  FX3 thread 0 ready, active-high.
- fx3Data  out  OUT_WIDTH  signed sample word to FX3 bus.
- fx3_nWrite  out  1  0 = fx3Data written this cycle.
- fx3_nError  out  1  0 = sticky overflow error.
- burstCount  out  16  completed-burst counter.

Function
REQ-004 The state machine SHALL have three states: IDLE, STREAM and GAP.
REQ-005 IDLE SHALL move to STREAM on the first cycle th0Ready=1; otherwise it SHALL remain in IDLE.
REQ-006 In STREAM, inReady SHALL be 1; in IDLE and GAP, inReady SHALL be 0.
REQ-007 Each accepted sample (inValid&inReady) SHALL produce exactly one write, with fx3Data registered and fx3_nWrite=0 on the following clock edge (1-cycle latency).
REQ-008 A STREAM cycle with inValid=0 SHALL be an underrun stall:
- fx3_nWrite=1 next cycle;
- word counter held;
- state unchanged;
- no error raised.
REQ-009 The word counter SHALL count accepted samples within the burst, 0..BURST_LEN-1.
REQ-010 The sample accepted at count BURST_LEN-1 SHALL cause:
- word counter reset to 0;
- burstCount increment, wrapping 0xFFFF->0x0000;
- transition to GAP.
REQ-011 No more than BURST_LEN writes SHALL occur per burst.
REQ-012 GAP SHALL last exactly GAP_CYCLES cycles, counted by the gap counter, then move to IDLE.
REQ-013 th0Ready SHALL be ignored during GAP.
REQ-014 th0Ready falling during STREAM SHALL NOT truncate the burst; FX3 buffer sizing guarantees space for BURST_LEN words.
REQ-015 Conversion SHALL be fx3Data = (src - 2^(ADC_WIDTH-1)) << (OUT_WIDTH-ADC_WIDTH), two's complement and exact, with no saturation required.
REQ-016 src SHALL be inData when testMode=0 and the ramp register when testMode=1.
REQ-017 The ramp register SHALL be ADC_WIDTH bits and increment by 1 on every accepted sample regardless of testMode, wrapping all-ones->0.
REQ-018 In testMode, input samples SHALL still be consumed (FIFO drains) and their data discarded.
REQ-019 testMode SHALL be sampled with the accepted sample; toggling mid-burst takes effect on the next accepted sample.
REQ-020 fifoFull=1 on any clock edge SHALL drive fx3_nError=0 from the next cycle; fx3_nError SHALL be sticky until reset.
REQ-021 fifoFull and the final burst sample on the same cycle SHALL both take effect: error set, burst completes normally.
REQ-022 Streaming SHALL continue after an error is flagged.
REQ-023 fx3_nWrite SHALL be 1 whenever fx3Data is not a new word.
REQ-024 fx3Data SHALL hold its last value while fx3_nWrite=1.

Reset
REQ-025 Asserting reset at any time, including mid-burst, SHALL immediately force:
- state IDLE;
- fx3_nWrite=1, fx3_nError=1, inReady=0;
- fx3Data=0;
- burstCount=0;
- word, gap and ramp counters = 0.
REQ-026 After reset deasserts, the first burst SHALL start at word 0 with ramp value 0.

Verification
REQ-027 (defaults, BURST_LEN=8, GAP_CYCLES=4) Conversion: inData 0x200, 0x3FF, 0x000 with th0Ready=1 -> fx3Data 0x0000, 0x7FC0, 0x8000, each one cycle after acceptance with fx3_nWrite=0.
REQ-028 Burst/gap: inValid held 1, th0Ready held 1 -> repeating pattern of 8 cycles fx3_nWrite=0, 4 gap cycles, 1 IDLE cycle; burstCount 0->1->2.
REQ-029 Underrun: inValid low for 3 cycles after word 3 -> exactly 3 cycles of fx3_nWrite=1 mid-burst; burst still totals 8 writes; burstCount increments once.
REQ-030 Test mode: testMode=1, 2 bursts -> fx3Data sequence (ramp 0..15 offset-converted) 0x8000, 0x8040, 0x8080, ..., 0x83C0 with no discontinuity across the gap.
REQ-031 Error: fifoFull pulsed 1 cycle mid-burst -> fx3_nError=0 next cycle and held; writes unaffected.
REQ-032 Reset: reset asserted at word 5 -> fx3_nWrite=1 and fx3_nError=1 immediately, burstCount=0; next burst delivers 8 words starting with ramp 0.

Source files
------------

// File: rtl/fx3_stream_engine.sv
// ADC-to-FX3 GPIF streaming engine: offset-binary to two's-complement conversion,
// fixed-length bursts separated by a minimum idle gap, and a sticky overflow flag.
module fx3_stream_engine #(
    parameter int unsigned ADC_WIDTH  = 10,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned BURST_LEN  = 8192,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADC_WIDTH-1:0] inData,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic                 fifoFull,
    input  logic                 testMode,
    input  logic                 th0Ready,
    output logic [OUT_WIDTH-1:0] fx3Data,
    output logic                 fx3_nWrite,
    output logic                 fx3_nError,
    output logic [15:0]          burstCount
);

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    localparam logic [15:0] LAST_WORD = 16'(BURST_LEN - 1);
    localparam logic [7:0]  LAST_GAP  = 8'(GAP_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [15:0]            word_q, word_d;
    logic [7:0]             gap_q, gap_d;
    logic [ADC_WIDTH-1:0]   ramp_q, ramp_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   nwrite_q, nwrite_d;
    logic                   err_q, err_d;
    logic [15:0]            burst_q, burst_d;

    logic                   accept;
    logic [ADC_WIDTH-1:0]   src;
    logic [OUT_WIDTH-1:0]   conv;

    assign inReady = (state_q == STREAM);
    assign accept  = inValid & inReady;
    assign src     = testMode ? ramp_q : inData;
    // Subtracting half-scale from offset binary is just an MSB flip; the left shift
    // then places the sample in the top ADC_WIDTH bits of the output word.
    assign conv    = OUT_WIDTH'({~src[ADC_WIDTH-1], src[ADC_WIDTH-2:0]}) << (OUT_WIDTH - ADC_WIDTH);

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        gap_d    = gap_q;
        ramp_d   = ramp_q;
        data_d   = data_q;
        burst_d  = burst_q;
        nwrite_d = 1'b1;
        err_d    = err_q | fifoFull;
        case (state_q)
            IDLE: begin
                if (th0Ready) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // th0Ready is deliberately not looked at: a started burst always completes.
                if (accept) begin
                    data_d   = conv;
                    nwrite_d = 1'b0;
                    ramp_d   = ramp_q + 1'b1;
                    if (word_q == LAST_WORD) begin
                        word_d  = 16'd0;
                        burst_d = burst_q + 16'd1;
                        gap_d   = 8'd0;
                        state_d = GAP;
                    end else begin
                        word_d = word_q + 16'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q == LAST_GAP) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            word_q   <= '0;
            gap_q    <= '0;
            ramp_q   <= '0;
            data_q   <= '0;
            nwrite_q <= 1'b1;
            err_q    <= 1'b0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            gap_q    <= gap_d;
            ramp_q   <= ramp_d;
            data_q   <= data_d;
            nwrite_q <= nwrite_d;
            err_q    <= err_d;
            burst_q  <= burst_d;
        end
    end

    assign fx3Data    = data_q;
    assign fx3_nWrite = nwrite_q;
    assign fx3_nError = ~err_q;
    assign burstCount = burst_q;

endmodule

// File: tb/tb_fx3_stream_engine.sv
// Bench for fx3_stream_engine: directed scenarios with constant expectations plus a
// randomized run scored against a transaction-level reference model.
module tb_fx3_stream_engine;

    localparam int ADC = 10;
    localparam int OUT = 16;
    localparam int BL  = 8;
    localparam int GP  = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [ADC-1:0]  inData = '0;
    logic            inValid = 1'b0;
    logic            inReady;
    logic            fifoFull = 1'b0;
    logic            testMode = 1'b0;
    logic            th0Ready = 1'b0;
    logic [OUT-1:0]  fx3Data;
    logic            fx3_nWrite;
    logic            fx3_nError;
    logic [15:0]     burstCount;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0=idle, 1=stream, 2=gap
    int          m_phase, m_word, m_gap, m_ramp, m_bursts;
    bit          m_err, m_nwrite;
    logic [15:0] m_data;

    fx3_stream_engine #(.ADC_WIDTH(ADC), .OUT_WIDTH(OUT), .BURST_LEN(BL), .GAP_CYCLES(GP)) dut (
        .clock(clock), .reset(reset), .inData(inData), .inValid(inValid), .inReady(inReady),
        .fifoFull(fifoFull), .testMode(testMode), .th0Ready(th0Ready), .fx3Data(fx3Data),
        .fx3_nWrite(fx3_nWrite), .fx3_nError(fx3_nError), .burstCount(burstCount)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] conv(input int src);
        int v;
        v = (src - (1 << (ADC - 1))) * (1 << (OUT - ADC));
        return 16'(v);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_word = 0; m_gap = 0; m_ramp = 0; m_bursts = 0;
        m_err = 0; m_nwrite = 1; m_data = 16'h0000;
    endtask

    // Advance one clock: update the model from the current inputs, then sample 1 ns after the edge.
    task automatic tick();
        int  old_phase;
        int  src;
        bit  acc;
        old_phase = m_phase;
        acc = (old_phase == 1) && inValid;
        if (fifoFull) m_err = 1;
        m_nwrite = 1;
        if (acc) begin
            src = testMode ? m_ramp : int'(inData);
            m_data = conv(src);
            m_nwrite = 0;
            m_ramp = (m_ramp + 1) % (1 << ADC);
            m_word++;
            if (m_word == BL) begin
                m_word = 0;
                m_bursts = (m_bursts + 1) % 65536;
                m_phase = 2;
                m_gap = GP;
            end
        end else if (old_phase == 0 && th0Ready) begin
            m_phase = 1;
        end else if (old_phase == 2) begin
            m_gap--;
            if (m_gap == 0) m_phase = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        model_reset();
        reset = 1'b0;
    endtask

    task automatic clear_inputs();
        inValid = 0; th0Ready = 0; fifoFull = 0; testMode = 0; inData = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        @(posedge clock); #1;
        do_reset();
        checks++;
        if (fx3_nWrite !== 1'b1 || fx3_nError !== 1'b1 || inReady !== 1'b0 ||
            fx3Data !== 16'h0000 || burstCount !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: got nWrite=%b nError=%b inReady=%b data=%h bursts=%h expected 1 1 0 0000 0000",
                     fx3_nWrite, fx3_nError, inReady, fx3Data, burstCount);
        end
    endtask

    task automatic test_conversion();
        logic [ADC-1:0] vin [3];
        logic [15:0]    vexp [3];
        vin[0] = 10'h200; vin[1] = 10'h3FF; vin[2] = 10'h000;
        vexp[0] = 16'h0000; vexp[1] = 16'h7FC0; vexp[2] = 16'h8000;
        clear_inputs();
        do_reset();
        th0Ready = 1;
        tick();
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL conv_ready: got inReady=%b expected 1", inReady);
        end
        for (int i = 0; i < 3; i++) begin
            inValid = 1; inData = vin[i];
            tick();
            checks++;
            if (fx3_nWrite !== 1'b0 || fx3Data !== vexp[i]) begin
                errors++;
                $display("FAIL conv_%0d: got nWrite=%b data=%h expected 0 %h", i, fx3_nWrite, fx3Data, vexp[i]);
            end
        end
    endtask

    task automatic test_burst_gap();
        bit          exp_nw;
        logic [15:0] exp_bc;
        clear_inputs();
        do_reset();
        th0Ready = 1; inValid = 1;
        for (int e = 1; e <= 30; e++) begin
            inData = ADC'($urandom);
            tick();
            exp_nw = (e < 2) ? 1'b1 : !(((e - 2) % 13) < 8);
            exp_bc = (e < 9) ? 16'd0 : 16'((e - 9) / 13 + 1);
            checks++;
            if (fx3_nWrite !== exp_nw || burstCount !== exp_bc) begin
                errors++;
                $display("FAIL burst_gap_cycle%0d: got nWrite=%b bursts=%0d expected %b %0d",
                         e, fx3_nWrite, burstCount, exp_nw, exp_bc);
            end
        end
    endtask

    task automatic test_underrun();
        int writes;
        clear_inputs();
        do_reset();
        writes = 0;
        th0Ready = 1; inValid = 1;
        tick();
        th0Ready = 0;
        for (int i = 0; i < 4; i++) begin
            inData = ADC'($urandom);
            tick();
            if (fx3_nWrite === 1'b0) writes++;
        end
        inValid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (fx3_nWrite !== 1'b1 || inReady !== 1'b1) begin
                errors++;
                $display("FAIL underrun_stall%0d: got nWrite=%b inReady=%b expected 1 1", i, fx3_nWrite, inReady);
            end
        end
        inValid = 1;
        for (int i = 0; i < 12; i++) begin
            inData = ADC'($urandom);
            tick();
            if (fx3_nWrite === 1'b0) writes++;
        end
        checks++;
        if (writes != BL || burstCount !== 16'd1) begin
            errors++;
            $display("FAIL underrun_total: got writes=%0d bursts=%0d expected %0d 1", writes, burstCount, BL);
        end
    endtask

    task automatic test_testmode();
        int          n;
        logic [15:0] exp_w;
        clear_inputs();
        do_reset();
        testMode = 1; th0Ready = 1; inValid = 1;
        n = 0;
        for (int e = 0; e < 22; e++) begin
            inData = ADC'($urandom);
            tick();
            if (fx3_nWrite === 1'b0) begin
                exp_w = 16'(16'h8000 + n * 16'h0040);
                checks++;
                if (fx3Data !== exp_w) begin
                    errors++;
                    $display("FAIL testmode_word%0d: got %h expected %h", n, fx3Data, exp_w);
                end
                n++;
            end
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL testmode_count: got %0d words expected 16", n);
        end
    endtask

    task automatic test_error();
        int writes;
        clear_inputs();
        do_reset();
        th0Ready = 1; inValid = 1;
        writes = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fx3_nWrite === 1'b0) writes++;
        end
        checks++;
        if (fx3_nError !== 1'b1) begin
            errors++;
            $display("FAIL error_before: got nError=%b expected 1", fx3_nError);
        end
        fifoFull = 1;
        tick();
        if (fx3_nWrite === 1'b0) writes++;
        fifoFull = 0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (fx3_nError !== 1'b0) begin
                errors++;
                $display("FAIL error_sticky%0d: got nError=%b expected 0", i, fx3_nError);
            end
            tick();
            if (fx3_nWrite === 1'b0) writes++;
        end
        checks++;
        if (writes != BL) begin
            errors++;
            $display("FAIL error_writes: got %0d expected %0d", writes, BL);
        end
    endtask

    task automatic test_reset_midburst();
        int n;
        clear_inputs();
        do_reset();
        testMode = 1; th0Ready = 1; inValid = 1;
        for (int i = 0; i < 14; i++) tick();
        fifoFull = 1;
        tick();
        fifoFull = 0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        #2;
        checks++;
        if (fx3_nWrite !== 1'b1 || fx3_nError !== 1'b1 || burstCount !== 16'd0 ||
            inReady !== 1'b0 || fx3Data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_midburst: got nWrite=%b nError=%b bursts=%0d inReady=%b data=%h expected 1 1 0 0 0000",
                     fx3_nWrite, fx3_nError, burstCount, inReady, fx3Data);
        end
        model_reset();
        #1;
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (fx3_nWrite === 1'b0) begin
                checks++;
                if (fx3Data !== 16'(16'h8000 + n * 16'h0040)) begin
                    errors++;
                    $display("FAIL post_reset_word%0d: got %h expected %h", n, fx3Data, 16'(16'h8000 + n * 16'h0040));
                end
                n++;
            end
        end
        checks++;
        if (n != BL) begin
            errors++;
            $display("FAIL post_reset_count: got %0d expected %0d", n, BL);
        end
    endtask

    task automatic test_random();
        clear_inputs();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) testMode = 1'($urandom_range(1));
            inValid  = ($urandom_range(3) != 0);
            th0Ready = 1'($urandom_range(1));
            fifoFull = ($urandom_range(199) == 0);
            inData   = ADC'($urandom);
            tick();
            checks++;
            if (inReady !== (m_phase == 1) || fx3_nWrite !== m_nwrite || fx3Data !== m_data ||
                fx3_nError !== !m_err || burstCount !== 16'(m_bursts)) begin
                errors++;
                $display("FAIL random_cycle%0d: got rdy=%b nW=%b d=%h nE=%b bc=%0d expected %b %b %h %b %0d",
                         c, inReady, fx3_nWrite, fx3Data, fx3_nError, burstCount,
                         (m_phase == 1), m_nwrite, m_data, !m_err, m_bursts);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_conversion();
        test_burst_gap();
        test_underrun();
        test_testmode();
        test_error();
        test_reset_midburst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
